// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_isa_pkg
// Brief    : Opcode/funct encodings decoded by the single-cycle MIPS controller
//            and the state encoding of the boot-time instruction loader.
// Revision : 1.0 - initial release
// ============================================================================
package mips_isa_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_R_TYPE = 6'h00;
    localparam logic [5:0] c_BLTZ   = 6'h01;  // REGIMM group, rt selects BLTZ/BGEZ
    localparam logic [5:0] c_J      = 6'h02;
    localparam logic [5:0] c_JAL    = 6'h03;
    localparam logic [5:0] c_BEQ    = 6'h04;
    localparam logic [5:0] c_BNE    = 6'h05;
    localparam logic [5:0] c_BLEZ   = 6'h06;
    localparam logic [5:0] c_BGTZ   = 6'h07;
    localparam logic [5:0] c_ADDI   = 6'h08;
    localparam logic [5:0] c_ADDIU  = 6'h09;
    localparam logic [5:0] c_SLTI   = 6'h0a;
    localparam logic [5:0] c_SLTIU  = 6'h0b;
    localparam logic [5:0] c_ANDI   = 6'h0c;
    localparam logic [5:0] c_LUI    = 6'h0f;
    localparam logic [5:0] c_LW     = 6'h23;
    localparam logic [5:0] c_SW     = 6'h2b;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] c_SLL_F  = 6'h00;
    localparam logic [5:0] c_SRL_F  = 6'h02;
    localparam logic [5:0] c_SRA_F  = 6'h03;
    localparam logic [5:0] c_JR_F   = 6'h08;
    localparam logic [5:0] c_JALR_F = 6'h09;
    localparam logic [5:0] c_ADD_F  = 6'h20;
    localparam logic [5:0] c_ADDU_F = 6'h21;
    localparam logic [5:0] c_SUB_F  = 6'h22;
    localparam logic [5:0] c_SUBU_F = 6'h23;
    localparam logic [5:0] c_AND_F  = 6'h24;
    localparam logic [5:0] c_OR_F   = 6'h25;
    localparam logic [5:0] c_XOR_F  = 6'h26;
    localparam logic [5:0] c_NOR_F  = 6'h27;
    localparam logic [5:0] c_SLT_F  = 6'h2a;
    localparam logic [5:0] c_SLTU_F = 6'h2b;

    typedef enum logic [2:0] {
        HDR_HI = 3'd0,
        HDR_LO = 3'd1,
        BYTES  = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } loaderState_t;

endpackage
`default_nettype wire

// File: rtl/isa_legal_check.sv
`default_nettype none
// ============================================================================
// Module   : isa_legal_check
// Brief    : Combinational check that an instruction word uses an opcode/funct
//            pair the single-cycle controller actually decodes.
// Revision : 1.0 - initial release
// ============================================================================
module isa_legal_check
    import mips_isa_pkg::*;
(
    input  logic [31:0] word,
    output logic        legal
);

    logic [5:0] w_opCode;
    logic [5:0] w_funct;
    logic       w_unusedFields;

    assign w_opCode       = word[31:26];
    assign w_funct        = word[5:0];
    // Register/immediate fields never affect legality.
    assign w_unusedFields = ^word[25:6];

    always_comb begin
        legal = 1'b0;
        case (w_opCode)
            c_R_TYPE: begin
                case (w_funct)
                    c_SLL_F, c_SRL_F, c_SRA_F, c_JR_F, c_JALR_F,
                    c_ADD_F, c_ADDU_F, c_SUB_F, c_SUBU_F,
                    c_AND_F, c_OR_F, c_XOR_F, c_NOR_F,
                    c_SLT_F, c_SLTU_F: legal = 1'b1;
                    default:           legal = 1'b0;
                endcase
            end
            c_BLTZ, c_J, c_JAL, c_BEQ, c_BNE, c_BLEZ, c_BGTZ,
            c_ADDI, c_ADDIU, c_SLTI, c_SLTIU, c_ANDI, c_LUI,
            c_LW, c_SW:        legal = 1'b1;
            default:           legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot loader: big-endian byte stream -> sequential instruction
//            memory writes, CPU held in reset until the load completes.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_oversize,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] illegal_addr
);

    localparam logic [63:0] c_DEPTH = 64'd1 << ADDR_W;

    loaderState_t      r_state;
    loaderState_t      w_nextState;
    logic [7:0]        r_cntHi;
    logic [CNT_W-1:0]  w_hdrCount;
    logic [CNT_W-1:0]  r_wordsLeft;
    logic [1:0]        r_byteIdx;
    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_illegalAddr;
    logic              r_errIllegal;
    logic              w_legal;
    logic              w_lastWord;
    logic              w_oversize;

    assign w_hdrCount = CNT_W'({r_cntHi, in_data});
    assign w_oversize = 64'(w_hdrCount) > c_DEPTH;
    assign w_lastWord = (r_wordsLeft == CNT_W'(1));

    isa_legal_check u_legalCheck (
        .word  (r_word),
        .legal (w_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HDR_HI;
        end else begin
            r_state <= w_nextState;
        end
    end

    // in_ready is a pure state decode, so a transfer only needs in_valid here.
    always_comb begin
        w_nextState  = r_state;
        in_ready     = 1'b0;
        imem_we      = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        err_oversize = 1'b0;
        case (r_state)
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = HDR_LO;
                end
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_hdrCount == '0) begin
                        w_nextState = DONE;
                    end else if (w_oversize) begin
                        w_nextState = ERROR;
                    end else begin
                        w_nextState = BYTES;
                    end
                end
            end
            BYTES: begin
                in_ready = 1'b1;
                if (in_valid && (r_byteIdx == 2'd3)) begin
                    w_nextState = WRITE;
                end
            end
            WRITE: begin
                imem_we     = 1'b1;
                w_nextState = w_lastWord ? DONE : BYTES;
            end
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    w_nextState = HDR_HI;
                end
            end
            ERROR: begin
                err_oversize = 1'b1;
                if (start) begin
                    w_nextState = HDR_HI;
                end
            end
            default: begin
                w_nextState = HDR_HI;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cntHi       <= '0;
            r_wordsLeft   <= '0;
            r_byteIdx     <= '0;
            r_word        <= '0;
            r_addr        <= '0;
            r_illegalAddr <= '0;
            r_errIllegal  <= 1'b0;
        end else begin
            case (r_state)
                HDR_HI: begin
                    if (in_valid) begin
                        r_cntHi <= in_data;
                    end
                end
                HDR_LO: begin
                    if (in_valid) begin
                        r_wordsLeft <= w_hdrCount;
                        r_byteIdx   <= '0;
                        r_addr      <= '0;
                    end
                end
                BYTES: begin
                    if (in_valid) begin
                        r_word    <= {r_word[23:0], in_data};
                        r_byteIdx <= r_byteIdx + 2'd1;
                    end
                end
                WRITE: begin
                    r_wordsLeft <= r_wordsLeft - CNT_W'(1);
                    // Holding on the last word keeps a full-depth load from wrapping to 0.
                    if (!w_lastWord) begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                    if (!w_legal && !r_errIllegal) begin
                        r_errIllegal  <= 1'b1;
                        r_illegalAddr <= r_addr;
                    end
                end
                DONE, ERROR: begin
                    if (start) begin
                        r_errIllegal  <= 1'b0;
                        r_illegalAddr <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr    = r_addr;
    assign imem_wdata   = r_word;
    assign err_illegal  = r_errIllegal;
    assign illegal_addr = r_illegalAddr;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed, table-driven bench for imem_loader (ADDR_W=8 and 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start,  start2;
    logic [7:0]  in_data, in_data2;
    logic        in_valid, in_valid2;

    logic        in_ready, imem_we, cpu_hold, done, err_oversize, err_illegal;
    logic [7:0]  imem_addr, illegal_addr;
    logic [31:0] imem_wdata;

    logic        in_ready2, imem_we2, cpu_hold2, done2, err_oversize2, err_illegal2;
    logic [1:0]  imem_addr2, illegal_addr2;
    logic [31:0] imem_wdata2;

    imem_loader #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err_oversize(err_oversize),
        .err_illegal(err_illegal), .illegal_addr(illegal_addr)
    );

    imem_loader #(.ADDR_W(2), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .cpu_hold(cpu_hold2), .done(done2), .err_oversize(err_oversize2),
        .err_illegal(err_illegal2), .illegal_addr(illegal_addr2)
    );

    // Write logs, sampled on the falling edge
    logic [7:0]  logAddr[$];
    logic [31:0] logData[$];
    logic [1:0]  logAddr2[$];
    logic [31:0] logData2[$];

    always @(negedge clk) begin
        if (imem_we) begin
            logAddr.push_back(imem_addr);
            logData.push_back(imem_wdata);
        end
        if (imem_we2) begin
            logAddr2.push_back(imem_addr2);
            logData2.push_back(imem_wdata2);
        end
    end

    int nCmp  = 0;
    int nFail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one byte from a falling edge and returns on the falling edge
    // after the rising edge that consumed it.
    task automatic sendByte(input bit sel, input logic [7:0] b, input int gap);
        bit ok;
        if (gap > 0) begin
            if (sel) in_valid2 = 1'b0; else in_valid = 1'b0;
            waitCyc(gap);
        end
        if (sel) begin in_data2 = b; in_valid2 = 1'b1; end
        else     begin in_data  = b; in_valid  = 1'b1; end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = sel ? in_ready2 : in_ready;
            @(negedge clk);
        end
        if (!ok) begin
            nCmp++;
            nFail++;
            $display("FAIL handshake_timeout: byte %h not accepted, required within 40 cycles", b);
        end
    endtask

    task automatic pulseStart(input bit sel);
        if (sel) start2 = 1'b1; else start = 1'b1;
        waitCyc(1);
        if (sel) start2 = 1'b0; else start = 1'b0;
        waitCyc(1);
    endtask

    typedef struct {
        int           nb;
        logic [0:13][7:0] bytes;
        int           nw;
        logic [0:2][31:0] expData;
        logic         expDone;
        logic         expOvs;
        logic         expIll;
        logic [7:0]   expIllAddr;
    } vec_t;

    function automatic vec_t mk(input int nb, input logic [111:0] b, input int nw,
                                input logic [95:0] d, input logic dn, input logic ov,
                                input logic il, input logic [7:0] ia);
        vec_t v;
        v.nb = nb; v.bytes = b; v.nw = nw; v.expData = d;
        v.expDone = dn; v.expOvs = ov; v.expIll = il; v.expIllAddr = ia;
        return v;
    endfunction

    vec_t vec[6];

    initial begin
        // lw + jr; empty load; oversize 257; illegal opcode/funct mix; all-legal; two illegal
        vec[0] = mk(10, 112'h0002_8C080004_00000008_00000000, 2, 96'h8C080004_00000008_00000000, 1, 0, 0, 8'h00);
        vec[1] = mk( 2, 112'h0000_00000000_00000000_00000000, 0, 96'h0,                         1, 0, 0, 8'h00);
        vec[2] = mk( 2, 112'h0101_00000000_00000000_00000000, 0, 96'h0,                         0, 1, 0, 8'h00);
        vec[3] = mk(14, 112'h0003_20010005_FC000000_0000003F, 3, 96'h20010005_FC000000_0000003F, 1, 0, 1, 8'h01);
        vec[4] = mk(10, 112'h0002_3C011234_0000002A_00000000, 2, 96'h3C011234_0000002A_00000000, 1, 0, 0, 8'h00);
        vec[5] = mk(10, 112'h0002_34000000_00000001_00000000, 2, 96'h34000000_00000001_00000000, 1, 0, 1, 8'h00);

        reset = 1'b0; start = 1'b0; start2 = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; in_data2 = 8'h00; in_valid2 = 1'b0;
        waitCyc(2);
        chk("rst_in_ready",     32'(in_ready),     32'd1);
        chk("rst_cpu_hold",     32'(cpu_hold),     32'd1);
        chk("rst_done",         32'(done),         32'd0);
        chk("rst_imem_we",      32'(imem_we),      32'd0);
        chk("rst_err_oversize", 32'(err_oversize), 32'd0);
        chk("rst_err_illegal",  32'(err_illegal),  32'd0);
        chk("rst_imem_addr",    32'(imem_addr),    32'd0);
        chk("rst_imem_wdata",   imem_wdata,        32'd0);
        chk("rst2_in_ready",    32'(in_ready2),    32'd1);
        chk("rst2_cpu_hold",    32'(cpu_hold2),    32'd1);
        reset = 1'b1;
        waitCyc(1);

        for (int v = 0; v < 6; v++) begin
            logAddr.delete(); logData.delete();
            for (int k = 0; k < vec[v].nb; k++) sendByte(0, vec[v].bytes[k], 0);
            in_valid = 1'b0;
            waitCyc(3);
            chk($sformatf("v%0d_done", v),         32'(done),         32'(vec[v].expDone));
            chk($sformatf("v%0d_err_oversize", v), 32'(err_oversize), 32'(vec[v].expOvs));
            chk($sformatf("v%0d_cpu_hold", v),     32'(cpu_hold),     32'(!vec[v].expDone));
            chk($sformatf("v%0d_in_ready", v),     32'(in_ready),     32'd0);
            chk($sformatf("v%0d_err_illegal", v),  32'(err_illegal),  32'(vec[v].expIll));
            chk($sformatf("v%0d_illegal_addr", v), 32'(illegal_addr), 32'(vec[v].expIllAddr));
            chk($sformatf("v%0d_nwrites", v),      32'(logAddr.size()), 32'(vec[v].nw));
            for (int k = 0; k < vec[v].nw && k < logAddr.size(); k++) begin
                chk($sformatf("v%0d_w%0d_addr", v, k), 32'(logAddr[k]), 32'(k));
                chk($sformatf("v%0d_w%0d_data", v, k), logData[k],      vec[v].expData[k]);
            end
            pulseStart(0);
            chk($sformatf("v%0d_rearm_in_ready", v),    32'(in_ready),     32'd1);
            chk($sformatf("v%0d_rearm_cpu_hold", v),    32'(cpu_hold),     32'd1);
            chk($sformatf("v%0d_rearm_done", v),        32'(done),         32'd0);
            chk($sformatf("v%0d_rearm_oversize", v),    32'(err_oversize), 32'd0);
            chk($sformatf("v%0d_rearm_err_illegal", v), 32'(err_illegal),  32'd0);
            chk($sformatf("v%0d_rearm_illegal_addr", v), 32'(illegal_addr), 32'd0);
        end

        // Empty header: DONE right after the second byte
        sendByte(0, 8'h00, 0);
        sendByte(0, 8'h00, 0);
        in_valid = 1'b0;
        chk("empty_done_immediate", 32'(done), 32'd1);
        pulseStart(0);

        // Random in_valid gaps, then async reset after two bytes of word 0
        logAddr.delete(); logData.delete();
        sendByte(0, 8'h00, int'($urandom_range(0, 3)));
        sendByte(0, 8'h01, int'($urandom_range(0, 3)));
        sendByte(0, 8'h8C, int'($urandom_range(0, 3)));
        sendByte(0, 8'h08, int'($urandom_range(0, 3)));
        in_valid = 1'b0;
        waitCyc(int'($urandom_range(1, 4)));
        chk("partial_hold_in_ready", 32'(in_ready), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_imem_we",  32'(imem_we),  32'd0);
        waitCyc(1);
        reset = 1'b1;
        waitCyc(1);
        chk("midrst_no_writes", 32'(logAddr.size()), 32'd0);
        sendByte(0, 8'h00, int'($urandom_range(0, 3)));
        sendByte(0, 8'h01, int'($urandom_range(0, 3)));
        sendByte(0, 8'h8C, int'($urandom_range(0, 3)));
        sendByte(0, 8'h08, int'($urandom_range(0, 3)));
        sendByte(0, 8'h00, int'($urandom_range(0, 3)));
        sendByte(0, 8'h04, int'($urandom_range(0, 3)));
        in_valid = 1'b0;
        waitCyc(3);
        chk("reload_nwrites", 32'(logAddr.size()), 32'd1);
        if (logAddr.size() > 0) begin
            chk("reload_addr", 32'(logAddr[0]), 32'd0);
            chk("reload_data", logData[0],      32'h8C080004);
        end
        chk("reload_done", 32'(done), 32'd1);
        pulseStart(0);

        // start pulses mid-load are ignored
        logAddr.delete(); logData.delete();
        sendByte(0, 8'h00, 0);
        start = 1'b1;
        sendByte(0, 8'h01, 0);
        sendByte(0, 8'h00, 0);
        start = 1'b0;
        sendByte(0, 8'h00, 0);
        sendByte(0, 8'h00, 0);
        start = 1'b1;
        sendByte(0, 8'h20, 0);
        start = 1'b0;
        in_valid = 1'b0;
        waitCyc(3);
        chk("startign_nwrites", 32'(logAddr.size()), 32'd1);
        if (logData.size() > 0) chk("startign_data", logData[0], 32'h00000020);
        chk("startign_done", 32'(done), 32'd1);

        // ADDR_W=2: full-depth load of 4 words, then oversize by one
        logAddr2.delete(); logData2.delete();
        sendByte(1, 8'h00, 0);
        sendByte(1, 8'h04, 0);
        for (int w = 0; w < 4; w++) begin
            logic [31:0] wd;
            case (w)
                0: wd = 32'h24420001;
                1: wd = 32'hAC430008;
                2: wd = 32'h1000FFFF;
                default: wd = 32'h08000000;
            endcase
            for (int k = 0; k < 4; k++) sendByte(1, wd[31-8*k -: 8], 0);
            chk($sformatf("d2_w%0d_latency_we", w), 32'(imem_we2),   32'd1);
            chk($sformatf("d2_w%0d_addr_now", w),   32'(imem_addr2), 32'(w));
        end
        in_valid2 = 1'b0;
        waitCyc(3);
        chk("d2_nwrites", 32'(logAddr2.size()), 32'd4);
        for (int k = 0; k < 4 && k < logAddr2.size(); k++)
            chk($sformatf("d2_log%0d_addr", k), 32'(logAddr2[k]), 32'(k));
        if (logData2.size() == 4) begin
            chk("d2_log3_data", logData2[3], 32'h08000000);
            chk("d2_log0_data", logData2[0], 32'h24420001);
        end
        chk("d2_done",        32'(done2),        32'd1);
        chk("d2_cpu_hold",    32'(cpu_hold2),    32'd0);
        chk("d2_err_illegal", 32'(err_illegal2), 32'd0);
        pulseStart(1);
        sendByte(1, 8'h00, 0);
        sendByte(1, 8'h05, 0);
        in_valid2 = 1'b0;
        waitCyc(2);
        chk("d2_ovs_err",      32'(err_oversize2), 32'd1);
        chk("d2_ovs_in_ready", 32'(in_ready2),     32'd0);
        chk("d2_ovs_cpu_hold", 32'(cpu_hold2),     32'd1);
        pulseStart(1);
        chk("d2_rearm_in_ready", 32'(in_ready2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire
